uart_cfg: RTL and testbench
===========================

UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 240_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1_000_000; BAUD_CNT = CLK_FREQ/BAUD_RATE (integer), legal range 8..65535.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd; only honoured per REQ-029.
REQ-006 SHALL have ports: iCLK  in  1  system clock; iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: iRX  in  1  serial receive line; oTX  out  1  serial transmit line.
REQ-008 SHALL have ports: iTVALID  in  1  transmit request; oTREADY  out  1  transmitter can accept; iTDATA  in  DATA_BITS  byte to send; oTDONE  out  1  frame-sent pulse.
REQ-009 SHALL have ports: oRVALID  out  1  frame-received pulse; oRDATA  out  DATA_BITS  received data; oRERR_FRAME  out  1  stop-bit error; oRERR_PAR  out  1  parity error.

Function
REQ-010 Frame SHALL be: start (0), DATA_BITS data LSB first, optional parity bit, STOP_BITS stop bits (1); each bit exactly BAUD_CNT iCLK cycles.
REQ-011 iRX SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-012 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_PAR, R_STOP; R_PAR skipped when no parity.
REQ-013 R_IDLE -> R_START on synchronised iRX = 0; bit counter loads 1 in that cycle.
REQ-014 Each RX bit SHALL be sampled at counts BAUD_CNT/4, BAUD_CNT/2, 3*BAUD_CNT/4; bit value = majority of 3 samples, resolved at count BAUD_CNT.
REQ-015 Start bit resolved as 1 (glitch) -> R_IDLE, no output pulse.
REQ-016 Only first stop bit SHALL be checked; RX returns to R_IDLE at end of first stop bit regardless of STOP_BITS.
REQ-017 At end of first stop bit: oRVALID one-cycle pulse; oRDATA loaded; oRERR_FRAME = (stop sample 0); oRERR_PAR = parity mismatch; error flags valid only in oRVALID cycle, else 0.
REQ-018 oRDATA SHALL hold last value until next oRVALID, including frames with errors.
REQ-019 Frame error with line still 0 SHALL NOT restart reception until iRX seen 1 (break lockout).
REQ-020 TX FSM states SHALL be T_IDLE, T_START, T_DATA, T_PAR, T_STOP; oTREADY = 1 only in T_IDLE.
REQ-021 Transfer accepted when iTVALID & oTREADY at a rising edge; iTDATA captured that cycle; iTDATA changes afterwards ignored.
REQ-022 oTX SHALL go 0 on the edge following acceptance (latency 1 cycle) and hold 1 in T_IDLE.
REQ-023 oTDONE SHALL pulse one cycle on the last cycle of the final stop bit; T_IDLE entered next cycle.
REQ-024 iTVALID held high continuously SHALL yield frames separated by exactly 1 idle-high cycle.
REQ-025 RX and TX SHALL operate fully independently and concurrently.

Reset
REQ-026 On iRST_N low: oTX = 1, oTREADY = 0 until first edge after release, oTDONE = 0, oRVALID = 0, oRDATA = 0, both error flags = 0, both FSMs idle, counters 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately; oTX = 1 asynchronously; no oTDONE/oRVALID for the aborted frame.
REQ-028 After release RX SHALL require synchronised iRX = 1 before recognising a start bit.

Configuration
REQ-029 Macro UART_CFG_PARITY_EN defined: PARITY 1/2 inserts even/odd parity bit on TX and checks it on RX; PARITY 0 behaves as none.
REQ-030 Macro undefined: no parity logic, PARITY ignored, R_PAR/T_PAR absent, oRERR_PAR tied 0.

Verification (CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, BAUD_CNT=16)
REQ-031 DATA_BITS=8, STOP_BITS=1, no parity: send 0xA5 -> oTX 0,1,0,1,0,0,1,0,1,1 each 16 cycles; oTDONE at cycle 160 after acceptance.
REQ-032 Loopback oTX->iRX, 0x3C then 0xC3 back-to-back -> two oRVALID pulses, oRDATA 0x3C then 0xC3, no errors, 161 cycles between frame starts.
REQ-033 Macro defined, PARITY=1: inject 0x07 with parity 0 -> oRVALID with oRERR_PAR=1, oRDATA=0x07.
REQ-034 Inject 0x55 with stop bit 0 -> oRERR_FRAME=1; iRX held 0 further 100 cycles -> no new oRVALID.
REQ-035 iRX low pulse of 4 cycles -> no oRVALID; DATA_BITS=5, STOP_BITS=2: send 0x1F -> frame length 8*16 cycles.
REQ-036 Assert iRST_N low at cycle 50 of TX frame -> oTX=1 same cycle, no oTDONE; after release oTREADY=1 next edge.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: configurable UART with independent RX and TX.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Every bit lasts BAUD_CNT = CLK_FREQ/BAUD_RATE clocks. RX majority-votes three
// samples per bit. Parity logic is compiled in only when UART_CFG_PARITY_EN is
// defined. Without it, PARITY has no effect and oRERR_PAR is held at 0.
module uart_cfg #(
    parameter int CLK_FREQ  = 240_000_000,
    parameter int BAUD_RATE = 1_000_000,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iRX,
    output logic                 oTX,
    input  logic                 iTVALID,
    output logic                 oTREADY,
    input  logic [DATA_BITS-1:0] iTDATA,
    output logic                 oTDONE,
    output logic                 oRVALID,
    output logic [DATA_BITS-1:0] oRDATA,
    output logic                 oRERR_FRAME,
    output logic                 oRERR_PAR
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BAUD_CNT + 1);
    localparam int IW       = 3;

    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_CNT);
    localparam logic [CW-1:0] SMP_A   = CW'(BAUD_CNT / 4);
    localparam logic [CW-1:0] SMP_B   = CW'(BAUD_CNT / 2);
    localparam logic [CW-1:0] SMP_C   = CW'((3 * BAUD_CNT) / 4);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [IW-1:0] DIDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] SIDX_LAST = IW'(STOP_BITS - 1);

`ifdef UART_CFG_PARITY_EN
    localparam bit PAR_ON  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    // Parity bit that makes the frame even (PARITY=1) or odd (PARITY=2).
    function automatic logic par_calc(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    typedef enum logic [2:0] {
        T_IDLE = 3'd0, T_START = 3'd1, T_DATA = 3'd2, T_PAR = 3'd3, T_STOP = 3'd4
    } tx_state_e;
    typedef enum logic [2:0] {
        R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_PAR = 3'd3, R_STOP = 3'd4
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        T_IDLE = 3'd0, T_START = 3'd1, T_DATA = 3'd2, T_STOP = 3'd4
    } tx_state_e;
    typedef enum logic [2:0] {
        R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_STOP = 3'd4
    } rx_state_e;
`endif

    // Majority of the three per-bit samples.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // ------------------------------------------------------------------ TX
    tx_state_e            t_state_q, t_state_d;
    logic [CW-1:0]        t_cnt_q, t_cnt_d;
    logic [IW-1:0]        t_idx_q, t_idx_d;
    logic [DATA_BITS-1:0] t_sh_q, t_sh_d;
    logic                 rdy_q;
    logic                 t_bit_end;
`ifdef UART_CFG_PARITY_EN
    logic                 t_par_q, t_par_d;
`endif

    assign t_bit_end = (t_cnt_q == CNT_MAX);

    // TX control state; reset aborts a frame at once, ready rises on the first edge after release.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            t_state_q <= T_IDLE;
            t_cnt_q   <= '0;
            t_idx_q   <= '0;
            rdy_q     <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            t_cnt_q   <= t_cnt_d;
            t_idx_q   <= t_idx_d;
            rdy_q     <= 1'b1;
        end
    end

    // TX data holding registers (no reset needed, loaded on acceptance).
    always_ff @(posedge iCLK) begin
        t_sh_q  <= t_sh_d;
`ifdef UART_CFG_PARITY_EN
        t_par_q <= t_par_d;
`endif
    end

    // TX next state: bit timing, data shifting and frame sequencing.
    always_comb begin
        t_state_d = t_state_q;
        t_idx_d   = t_idx_q;
        t_sh_d    = t_sh_q;
`ifdef UART_CFG_PARITY_EN
        t_par_d   = t_par_q;
`endif
        if (t_state_q == T_IDLE) t_cnt_d = '0;
        else                     t_cnt_d = t_bit_end ? CNT_ONE : t_cnt_q + 1'b1;
        case (t_state_q)
            T_IDLE: begin
                if (iTVALID && rdy_q) begin
                    t_state_d = T_START;
                    t_cnt_d   = CNT_ONE;
                    t_idx_d   = '0;
                    t_sh_d    = iTDATA;
`ifdef UART_CFG_PARITY_EN
                    t_par_d   = par_calc(iTDATA);
`endif
                end
            end
            T_START: begin
                if (t_bit_end) begin
                    t_state_d = T_DATA;
                    t_idx_d   = '0;
                end
            end
            T_DATA: begin
                if (t_bit_end) begin
                    t_sh_d = t_sh_q >> 1;
                    if (t_idx_q == DIDX_LAST) begin
                        t_idx_d = '0;
`ifdef UART_CFG_PARITY_EN
                        t_state_d = PAR_ON ? T_PAR : T_STOP;
`else
                        t_state_d = T_STOP;
`endif
                    end else begin
                        t_idx_d = t_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_CFG_PARITY_EN
            T_PAR: begin
                if (t_bit_end) begin
                    t_state_d = T_STOP;
                    t_idx_d   = '0;
                end
            end
`endif
            T_STOP: begin
                if (t_bit_end) begin
                    if (t_idx_q == SIDX_LAST) t_state_d = T_IDLE;
                    else                      t_idx_d   = t_idx_q + 1'b1;
                end
            end
            default: t_state_d = T_IDLE;
        endcase
    end

    // TX outputs decoded from state; line idles high.
    always_comb begin
        oTX     = 1'b1;
        oTDONE  = 1'b0;
        oTREADY = rdy_q && (t_state_q == T_IDLE);
        case (t_state_q)
            T_START: oTX = 1'b0;
            T_DATA:  oTX = t_sh_q[0];
`ifdef UART_CFG_PARITY_EN
            T_PAR:   oTX = t_par_q;
`endif
            T_STOP:  oTDONE = t_bit_end && (t_idx_q == SIDX_LAST);
            default: oTX = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX
    rx_state_e            r_state_q, r_state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        r_cnt_q, r_cnt_d;
    logic [IW-1:0]        r_idx_q, r_idx_d;
    logic [2:0]           r_smp_q, r_smp_d;
    logic [DATA_BITS-1:0] r_sh_q, r_sh_d;
    logic                 arm_q, arm_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s, r_bit_end, r_bit;
`ifdef UART_CFG_PARITY_EN
    logic                 r_par_q, r_par_d;
    logic                 perr_q, perr_d;
`endif

    assign rx_s      = sync_q[1];
    assign r_bit_end = (r_cnt_q == CNT_MAX);
    assign r_bit     = maj3(r_smp_q);

    // RX synchroniser, control state and result registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q    <= 2'b11;
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            arm_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_CFG_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], iRX};
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            arm_q     <= arm_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ferr_q    <= ferr_d;
`ifdef UART_CFG_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // RX sample and shift registers (pure data, no reset).
    always_ff @(posedge iCLK) begin
        r_smp_q <= r_smp_d;
        r_sh_q  <= r_sh_d;
`ifdef UART_CFG_PARITY_EN
        r_par_q <= r_par_d;
`endif
    end

    // RX next state: start detection, 3-point sampling, frame checks.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_smp_d   = r_smp_q;
        r_sh_d    = r_sh_q;
        arm_d     = arm_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        ferr_d    = 1'b0;
`ifdef UART_CFG_PARITY_EN
        r_par_d   = r_par_q;
        perr_d    = 1'b0;
`endif
        if (r_state_q == R_IDLE) begin
            r_cnt_d = '0;
        end else begin
            r_cnt_d = r_bit_end ? CNT_ONE : r_cnt_q + 1'b1;
            if (r_cnt_q == SMP_A) r_smp_d[0] = rx_s;
            if (r_cnt_q == SMP_B) r_smp_d[1] = rx_s;
            if (r_cnt_q == SMP_C) r_smp_d[2] = rx_s;
        end
        case (r_state_q)
            R_IDLE: begin
                // A low line only starts a frame once it has been seen high
                // (after reset or after a frame error left the line low).
                if (rx_s) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    r_state_d = R_START;
                    r_cnt_d   = CNT_ONE;
                end
            end
            R_START: begin
                if (r_bit_end) begin
                    if (r_bit) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_DATA;
                        r_idx_d   = '0;
                    end
                end
            end
            R_DATA: begin
                if (r_bit_end) begin
                    r_sh_d = {r_bit, r_sh_q[DATA_BITS-1:1]};
                    if (r_idx_q == DIDX_LAST) begin
                        r_idx_d = '0;
`ifdef UART_CFG_PARITY_EN
                        r_state_d = PAR_ON ? R_PAR : R_STOP;
`else
                        r_state_d = R_STOP;
`endif
                    end else begin
                        r_idx_d = r_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_CFG_PARITY_EN
            R_PAR: begin
                if (r_bit_end) begin
                    r_par_d   = r_bit;
                    r_state_d = R_STOP;
                end
            end
`endif
            R_STOP: begin
                // Only the first stop bit is checked; extra stop bits are idle time.
                if (r_bit_end) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_sh_q;
                    ferr_d    = ~r_bit;
                    arm_d     = r_bit;
`ifdef UART_CFG_PARITY_EN
                    perr_d    = PAR_ON && (r_par_q != par_calc(r_sh_q));
`endif
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // RX outputs are the registered frame results.
    always_comb begin
        oRVALID     = rvalid_q;
        oRDATA      = rdata_q;
        oRERR_FRAME = ferr_q;
`ifdef UART_CFG_PARITY_EN
        oRERR_PAR   = perr_q;
`else
        // Parity is compiled out, so PARITY has no effect here.
        oRERR_PAR   = 1'b0 & (PARITY != 0);
`endif
    end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg at BAUD_CNT = 16.
// u0: 8 data bits, 1 stop, no parity, with a switchable oTX->iRX loopback.
// u1: 5 data bits, 2 stop, PARITY=1 (parity is active only with UART_CFG_PARITY_EN).
module tb_uart_cfg;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1, loop;
    logic       tvalid0, tvalid1;
    logic [7:0] tdata0;
    logic [4:0] tdata1;
    logic       tx0, tready0, done0, rvalid0, fe0, pe0;
    logic       tx1, tready1, done1, rvalid1, fe1, pe1;
    logic [7:0] rdata0;
    logic [4:0] rdata1;
    logic       rx0_line;

    int checks   = 0;
    int failures = 0;

    int         rv0_cnt = 0, rv1_cnt = 0, done0_cnt = 0;
    logic [7:0] rv0_data;
    logic [4:0] rv1_data;
    logic       rv0_fe, rv0_pe, rv1_fe, rv1_pe;

`ifdef UART_CFG_PARITY_EN
    localparam int U1_FRAME = 144;
    localparam logic U1_PE  = 1'b1;
`else
    localparam int U1_FRAME = 128;
    localparam logic U1_PE  = 1'b0;
`endif

    assign rx0_line = loop ? tx0 : rx0;

    always #5 clk = ~clk;

    uart_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000)) u0 (
        .iCLK(clk), .iRST_N(rst_n), .iRX(rx0_line), .oTX(tx0),
        .iTVALID(tvalid0), .oTREADY(tready0), .iTDATA(tdata0), .oTDONE(done0),
        .oRVALID(rvalid0), .oRDATA(rdata0), .oRERR_FRAME(fe0), .oRERR_PAR(pe0)
    );

    uart_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(5),
               .STOP_BITS(2), .PARITY(1)) u1 (
        .iCLK(clk), .iRST_N(rst_n), .iRX(rx1), .oTX(tx1),
        .iTVALID(tvalid1), .oTREADY(tready1), .iTDATA(tdata1), .oTDONE(done1),
        .oRVALID(rvalid1), .oRDATA(rdata1), .oRERR_FRAME(fe1), .oRERR_PAR(pe1)
    );

    // Pulse monitors, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rvalid0) begin
            rv0_cnt  <= rv0_cnt + 1;
            rv0_data <= rdata0;
            rv0_fe   <= fe0;
            rv0_pe   <= pe0;
        end
        if (rvalid1) begin
            rv1_cnt  <= rv1_cnt + 1;
            rv1_data <= rdata1;
            rv1_fe   <= fe1;
            rv1_pe   <= pe1;
        end
        if (done0) done0_cnt <= done0_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n frame bits (bit 0 first), 16 clocks each, onto rx0 (sel=0) or rx1.
    task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 16; c++) begin
                if (sel == 0) rx0 = bits[i];
                else          rx1 = bits[i];
                tick();
            end
        end
    endtask

    logic [9:0]  exp_a5;
    logic [15:0] fr;
    int          base, base_done, nacc, nrv, done_k;
    int          acc_cyc [2];
    logic [7:0]  rv_data [2];
    logic [1:0]  rv_err  [2];
    logic        acc;

    initial begin
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; loop = 1'b0;
        tvalid0 = 1'b0; tdata0 = 8'h00; tvalid1 = 1'b0; tdata1 = 5'h00;
        repeat (3) tick();

        // Reset state
        check("rst_tx", tx0, 1);
        check("rst_tready", tready0, 0);
        check("rst_tdone", done0, 0);
        check("rst_rvalid", rvalid0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_ferr", fe0, 0);
        check("rst_perr", pe0, 0);
        rst_n = 1'b1;
        check("rdy_before_edge", tready0, 0);
        tick();
        check("rdy_after_edge", tready0, 1);
        repeat (4) tick();

        // 0xA5 on u0: 0,1,0,1,0,0,1,0,1,1 with 16 clocks per bit, done in cycle 160
        exp_a5 = 10'b1101001010;
        tvalid0 = 1'b1; tdata0 = 8'hA5;
        check("a5_tready", tready0, 1);
        tick();
        tvalid0 = 1'b0; tdata0 = 8'hFF;
        for (int k = 1; k <= 160; k++) begin
            check($sformatf("a5_tx_c%0d", k), tx0, exp_a5[(k - 1) / 16]);
            check($sformatf("a5_done_c%0d", k), done0, (k == 160) ? 1 : 0);
            tick();
        end
        check("a5_idle_tx", tx0, 1);
        check("a5_idle_ready", tready0, 1);
        repeat (5) tick();

        // Loopback 0x3C then 0xC3 with iTVALID held
        loop = 1'b1; nacc = 0; nrv = 0;
        tvalid0 = 1'b1; tdata0 = 8'h3C;
        for (int k = 0; k < 400; k++) begin
            if (rvalid0) begin
                if (nrv < 2) begin
                    rv_data[nrv] = rdata0;
                    rv_err[nrv]  = {fe0, pe0};
                end
                nrv++;
            end
            acc = tvalid0 && tready0;
            if (acc) begin
                if (nacc < 2) acc_cyc[nacc] = k;
                nacc++;
            end
            tick();
            if (acc) begin
                if (nacc == 1) tdata0 = 8'hC3;
                else           tvalid0 = 1'b0;
            end
        end
        check("lb_accepts", nacc, 2);
        check("lb_start_gap", acc_cyc[1] - acc_cyc[0], 161);
        check("lb_rvalid_cnt", nrv, 2);
        check("lb_data0", rv_data[0], 8'h3C);
        check("lb_data1", rv_data[1], 8'hC3);
        check("lb_err0", rv_err[0], 0);
        check("lb_err1", rv_err[1], 0);
        loop = 1'b0; tvalid0 = 1'b0;
        repeat (20) tick();

        // 0x55 with stop bit 0, then line held low (break lockout)
        base = rv0_cnt;
        fr = {6'b0, 1'b0, 8'h55, 1'b0};
        drive_bits(0, fr, 10);
        repeat (8) tick();
        check("brk_rvalid", rv0_cnt, base + 1);
        check("brk_data", rv0_data, 8'h55);
        check("brk_ferr", rv0_fe, 1);
        check("brk_perr", rv0_pe, 0);
        repeat (92) tick();
        check("brk_lockout", rv0_cnt, base + 1);
        check("brk_hold_data", rdata0, 8'h55);
        check("brk_ferr_idle", fe0, 0);
        rx0 = 1'b1;
        repeat (20) tick();

        // 4-cycle low glitch is rejected
        base = rv0_cnt;
        rx0 = 1'b0;
        repeat (4) tick();
        rx0 = 1'b1;
        repeat (40) tick();
        check("glitch_no_rvalid", rv0_cnt, base);

        // Normal frame after break and glitch
        fr = {6'b0, 1'b1, 8'h81, 1'b0};
        drive_bits(0, fr, 10);
        repeat (8) tick();
        check("rec_rvalid", rv0_cnt, base + 1);
        check("rec_data", rv0_data, 8'h81);
        check("rec_ferr", rv0_fe, 0);

        // u1 transmit 0x1F: 5 data, 2 stop (+ parity bit when compiled in)
        done_k = -1;
        tvalid1 = 1'b1; tdata1 = 5'h1F;
        check("u1_tready", tready1, 1);
        tick();
        tvalid1 = 1'b0; tdata1 = 5'h00;
        for (int k = 1; k <= 300 && done_k < 0; k++) begin
            if (k == 1)   check("u1_start", tx1, 0);
            if (k == 20)  check("u1_bit0", tx1, 1);
            if (k == 104) check("u1_bit6", tx1, 1);
            if (done1) done_k = k;
            else       tick();
        end
        check("u1_frame_len", done_k, U1_FRAME);
        tick();
        check("u1_ready_after", tready1, 1);

        // u1 receive 0x07 with parity bit 0 (wrong for even parity)
        base = rv1_cnt;
`ifdef UART_CFG_PARITY_EN
        fr = {7'b0, 2'b11, 1'b0, 5'h07, 1'b0};
        drive_bits(1, fr, 9);
`else
        fr = {8'b0, 2'b11, 5'h07, 1'b0};
        drive_bits(1, fr, 8);
`endif
        repeat (8) tick();
        check("u1_rx_rvalid", rv1_cnt, base + 1);
        check("u1_rx_data", rv1_data, 5'h07);
        check("u1_rx_perr", rv1_pe, U1_PE);
        check("u1_rx_ferr", rv1_fe, 0);
`ifdef UART_CFG_PARITY_EN
        fr = {7'b0, 2'b11, 1'b0, 5'h03, 1'b0};
        drive_bits(1, fr, 9);
        repeat (8) tick();
        check("u1_rx_good_cnt", rv1_cnt, base + 2);
        check("u1_rx_good_data", rv1_data, 5'h03);
        check("u1_rx_good_perr", rv1_pe, 0);
`endif
        repeat (10) tick();

        // Reset asserted in cycle 50 of a u0 frame
        base_done = done0_cnt;
        base = rv0_cnt;
        tvalid0 = 1'b1; tdata0 = 8'h5A;
        check("mid_tready", tready0, 1);
        tick();
        tvalid0 = 1'b0;
        repeat (49) tick();
        check("mid_tx_before", tx0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_tx_async", tx0, 1);
        check("mid_tready_rst", tready0, 0);
        check("mid_tdone_rst", done0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        check("mid_ready_pre", tready0, 0);
        tick();
        check("mid_ready_post", tready0, 1);
        repeat (200) tick();
        check("mid_no_tdone", done0_cnt, base_done);
        check("mid_no_rvalid", rv0_cnt, base);
        check("mid_tx_idle", tx0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
